sram2tlul_ost: RTL and testbench
================================

SRAM2TLUL_OST -- requirements
Module: sram2tlul_ost

Interface
REQ-001 SHALL have parameter SramAw, default 12, SRAM word-address width (1..30).
REQ-002 SHALL have parameter Outstanding, default 4, maximum in-flight transactions (power of two, 1..16); SrcW = max(1, log2(Outstanding)).
REQ-003 SHALL have parameter TlBaseAddr, default 32'h0, OR-ed into every generated TL address.
REQ-004 clk_i  in  1  single clock, all logic on rising edge.
REQ-005 rst_i  in  1  reset, synchronous, active-high.
REQ-006 mem_req  in  1  SRAM-side request.
REQ-007 mem_gnt  out  1  request accepted this cycle (mem_req & tl_a_ready path).
REQ-008 mem_write  in  1  1 = write, 0 = read.
REQ-009 mem_addr  in  SramAw  word address.
REQ-010 mem_wmask  in  4  byte enables for writes.
REQ-011 mem_wdata  in  32  write data.
REQ-012 mem_rvalid  out  1  completion pulse, one per granted request.
REQ-013 mem_rdata  out  32  read data; 0 on write completions.
REQ-014 mem_error  out  2  {err,err} of the completion.
REQ-015 tl_a_valid  out  1  A-channel valid.
REQ-016 tl_a_ready  in  1  A-channel ready.
REQ-017 tl_a_opcode  out  3  Get 4, PutFullData 0, PutPartialData 1.
REQ-018 tl_a_address  out  32  TlBaseAddr | {mem_addr, 2'b00}, zero-extended.
REQ-019 tl_a_source  out  8  slot id in [SrcW-1:0], upper bits 0.
REQ-020 tl_a_mask  out  4  4'hF for reads, mem_wmask for writes.
REQ-021 tl_a_data  out  32  mem_wdata.
REQ-022 tl_d_valid  in  1  D-channel valid.
REQ-023 tl_d_ready  out  1  D-channel ready, constant 1 out of reset.
REQ-024 tl_d_opcode  in  3  AccessAck 0 / AccessAckData 1.
REQ-025 tl_d_source  in  8  returned source id.
REQ-026 tl_d_data  in  32  response data.
REQ-027 tl_d_error  in  1  response error.

Function
REQ-028 A channel SHALL be combinational pass-through: tl_a_valid = mem_req & ~full; mem_gnt = tl_a_valid & tl_a_ready; size fixed 2, no user bits.
REQ-029 Write opcode SHALL be PutFullData when mem_wmask == 4'hF, else PutPartialData.
REQ-030 Slots SHALL be allocated in order by a SrcW-bit write pointer, incremented on mem_gnt, wrapping Outstanding-1 -> 0; count of in-flight slots SHALL track grant/retire, full when count == Outstanding (grant blocked, mem_gnt 0).
REQ-031 D responses MAY arrive in any order; a beat with tl_d_source[SrcW-1:0] matching an allocated, not-yet-returned slot (upper bits 0) SHALL store data/error in that slot and mark it returned.
REQ-032 Completions SHALL be released strictly in grant order: when the slot at the read pointer is returned, mem_rvalid pulses the following cycle with its data/error; read pointer advances, slot freed.
REQ-033 Minimum latency: D beat in cycle N -> mem_rvalid in cycle N+1; at most one completion per cycle; throughput 1/cycle at steady state.
REQ-034 Grant and retire in the same cycle SHALL leave count unchanged; a slot freed this cycle SHALL be grantable the next cycle, not the same cycle.
REQ-035 D beats with unknown or already-returned source SHALL be discarded without state change.

Reset
REQ-036 While rst_i is high at a clock edge: pointers, count, slot valid/returned flags cleared; mem_rvalid 0, mem_rdata 0, mem_error 0, tl_d_ready 0, tl_a_valid 0 (the reset term gates it combinationally).
REQ-037 Reset mid-operation SHALL abandon all in-flight slots; late D beats after reset are discarded per REQ-035.

Configuration
REQ-038 With SRAM2TLUL_RSP_CHK_EN defined, a response whose opcode mismatches its request (read expects AccessAckData, write AccessAck) SHALL be completed with mem_error = 2'b11 and mem_rdata = 0; without it, opcode SHALL be ignored and only tl_d_error drives mem_error.

Verification
REQ-039 Read addr 12'h010, TlBaseAddr 32'h1000_0000 -> tl_a_address 32'h1000_0040, opcode 4, mask F; D data 32'hCAFE_F00D -> mem_rvalid with that data one cycle later.
REQ-040 Write mask 4'b0011 -> opcode 1, mask 3; AccessAck -> mem_rvalid, mem_rdata 0, mem_error 0.
REQ-041 Outstanding=4, tl_d_valid held low, 6 back-to-back reads -> exactly 4 grants, 5th blocked until a completion retires.
REQ-042 Sources 0,1,2 granted; D returns 2,0,1 -> mem_rvalid data ordered slot 0,1,2, source-1 data released the cycle after its beat.
REQ-043 tl_d_error=1 on slot 0 -> mem_error 2'b11; with SRAM2TLUL_RSP_CHK_EN, AccessAck to a read -> mem_error 2'b11, rdata 0.
REQ-044 rst_i asserted with 3 in flight, then stale D beats -> no mem_rvalid, first grant after reset uses source 0.

Source files
------------

// File: rtl/sram2tlul_ost.sv
`default_nettype none
// ============================================================================
// Module   : sram2tlul_ost
// Brief    : SRAM-style request port to TL-UL host bridge with multiple
//            outstanding transactions and in-order completion release.
//            Optional define SRAM2TLUL_RSP_CHK_EN adds response opcode checking.
// Revision : 1.0 - initial release
// ============================================================================
module sram2tlul_ost #(
  parameter int unsigned SramAw      = 12,
  parameter int unsigned Outstanding = 4,
  parameter logic [31:0] TlBaseAddr  = 32'h0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_req,
  output logic              mem_gnt,
  input  logic              mem_write,
  input  logic [SramAw-1:0] mem_addr,
  input  logic [3:0]        mem_wmask,
  input  logic [31:0]       mem_wdata,
  output logic              mem_rvalid,
  output logic [31:0]       mem_rdata,
  output logic [1:0]        mem_error,
  output logic              tl_a_valid,
  input  logic              tl_a_ready,
  output logic [2:0]        tl_a_opcode,
  output logic [31:0]       tl_a_address,
  output logic [7:0]        tl_a_source,
  output logic [3:0]        tl_a_mask,
  output logic [31:0]       tl_a_data,
  input  logic              tl_d_valid,
  output logic              tl_d_ready,
  input  logic [2:0]        tl_d_opcode,
  input  logic [7:0]        tl_d_source,
  input  logic [31:0]       tl_d_data,
  input  logic              tl_d_error
);

  localparam int unsigned c_SRC_W = (Outstanding > 1) ? $clog2(Outstanding) : 1;
  localparam int unsigned c_CNT_W = $clog2(Outstanding + 1);

  localparam logic [2:0] c_OP_GET       = 3'd4;
  localparam logic [2:0] c_OP_PUT_FULL  = 3'd0;
  localparam logic [2:0] c_OP_PUT_PART  = 3'd1;
  localparam logic [2:0] c_OP_ACK       = 3'd0;
  localparam logic [2:0] c_OP_ACK_DATA  = 3'd1;

  localparam logic [c_SRC_W-1:0] c_PTR_LAST = c_SRC_W'(Outstanding - 1);
  localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(Outstanding);

  logic [c_SRC_W-1:0]   r_wptr;
  logic [c_SRC_W-1:0]   r_rptr;
  logic [c_CNT_W-1:0]   r_count;
  logic [Outstanding-1:0] r_slot_vld;
  logic [Outstanding-1:0] r_slot_ret;
  logic [Outstanding-1:0] r_slot_wr;
  logic [Outstanding-1:0] r_slot_err;
  logic [31:0]          r_slot_data [Outstanding];
  logic                 r_d_ready;
  logic                 r_rvalid;
  logic [31:0]          r_rdata;
  logic                 r_err;

  logic                 w_full;
  logic                 w_a_valid;
  logic                 w_gnt;
  logic [c_SRC_W-1:0]   w_d_src;
  logic                 w_d_hit;
  logic                 w_d_wr;
  logic                 w_d_mis;
  logic                 w_d_err;
  logic [31:0]          w_d_data;
  logic                 w_head_byp;
  logic                 w_retire;
  logic [31:0]          w_ret_data;
  logic                 w_ret_err;
  logic [31:0]          w_addr_ext;

  function automatic logic [c_SRC_W-1:0] ptr_inc(input logic [c_SRC_W-1:0] p);
    return (p == c_PTR_LAST) ? '0 : p + c_SRC_W'(1);
  endfunction

  // A channel is a direct pass-through, gated by reset and the slot budget
  assign w_full     = (r_count == c_CNT_FULL);
  assign w_a_valid  = mem_req & ~w_full & ~rst_i;
  assign w_gnt      = w_a_valid & tl_a_ready;
  assign w_addr_ext = 32'({mem_addr, 2'b00});

  assign tl_a_valid   = w_a_valid;
  assign mem_gnt      = w_gnt;
  assign tl_a_address = TlBaseAddr | w_addr_ext;
  assign tl_a_source  = 8'(r_wptr);
  assign tl_a_mask    = mem_write ? mem_wmask : 4'hF;
  assign tl_a_data    = mem_wdata;
  assign tl_a_opcode  = !mem_write         ? c_OP_GET      :
                        (mem_wmask == 4'hF) ? c_OP_PUT_FULL : c_OP_PUT_PART;

  assign w_d_src = tl_d_source[c_SRC_W-1:0];
  assign w_d_hit = tl_d_valid & r_d_ready & ((tl_d_source >> c_SRC_W) == 8'd0) &
                   (w_d_src <= c_PTR_LAST) & r_slot_vld[w_d_src] & ~r_slot_ret[w_d_src];

  always_comb begin
    w_d_wr  = r_slot_wr[w_d_src];
    w_d_mis = 1'b0;
`ifdef SRAM2TLUL_RSP_CHK_EN
    w_d_mis = w_d_wr ? (tl_d_opcode != c_OP_ACK) : (tl_d_opcode != c_OP_ACK_DATA);
`endif
    w_d_err  = tl_d_error | w_d_mis;
    w_d_data = (w_d_wr | w_d_mis) ? 32'h0 : tl_d_data;
  end

`ifndef SRAM2TLUL_RSP_CHK_EN
  logic w_unused_opcode;
  assign w_unused_opcode = ^{tl_d_opcode, c_OP_ACK, c_OP_ACK_DATA};
`endif

  // A beat landing on the head slot is released at the same edge it is stored
  assign w_head_byp = w_d_hit & (w_d_src == r_rptr);
  assign w_retire   = r_slot_vld[r_rptr] & (r_slot_ret[r_rptr] | w_head_byp);
  assign w_ret_data = w_head_byp ? w_d_data : r_slot_data[r_rptr];
  assign w_ret_err  = w_head_byp ? w_d_err  : r_slot_err[r_rptr];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_slot_vld <= '0;
      r_slot_ret <= '0;
      r_slot_wr  <= '0;
      r_d_ready  <= 1'b0;
      r_rvalid   <= 1'b0;
      r_rdata    <= 32'h0;
      r_err      <= 1'b0;
    end else begin
      r_d_ready <= 1'b1;
      r_rvalid  <= w_retire;
      if (w_gnt) begin
        r_slot_vld[r_wptr] <= 1'b1;
        r_slot_ret[r_wptr] <= 1'b0;
        r_slot_wr[r_wptr]  <= mem_write;
        r_wptr             <= ptr_inc(r_wptr);
      end
      if (w_d_hit) begin
        r_slot_ret[w_d_src] <= 1'b1;
      end
      // Retire last so a bypassed head beat leaves its slot fully cleared
      if (w_retire) begin
        r_slot_vld[r_rptr] <= 1'b0;
        r_slot_ret[r_rptr] <= 1'b0;
        r_rptr             <= ptr_inc(r_rptr);
        r_rdata            <= w_ret_data;
        r_err              <= w_ret_err;
      end
      if (w_gnt && !w_retire) begin
        r_count <= r_count + c_CNT_W'(1);
      end else if (!w_gnt && w_retire) begin
        r_count <= r_count - c_CNT_W'(1);
      end
    end
  end

  // Payload storage is qualified by the slot flags and needs no reset
  always_ff @(posedge clk_i) begin
    if (w_d_hit) begin
      r_slot_data[w_d_src] <= w_d_data;
      r_slot_err[w_d_src]  <= w_d_err;
    end
  end

  assign tl_d_ready = r_d_ready;
  assign mem_rvalid = r_rvalid;
  assign mem_rdata  = r_rdata;
  assign mem_error  = {r_err, r_err};

endmodule
`default_nettype wire

// File: tb/tb_sram2tlul_ost.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram2tlul_ost
// Brief    : Directed and random checks of sram2tlul_ost against a queue model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram2tlul_ost;

  logic        clk;
  logic        rst;
  logic        mem_req, mem_write, mem_gnt, mem_rvalid;
  logic [11:0] mem_addr;
  logic [3:0]  mem_wmask;
  logic [31:0] mem_wdata, mem_rdata;
  logic [1:0]  mem_error;
  logic        tl_a_valid, tl_a_ready;
  logic [2:0]  tl_a_opcode;
  logic [31:0] tl_a_address, tl_a_data;
  logic [7:0]  tl_a_source;
  logic [3:0]  tl_a_mask;
  logic        tl_d_valid, tl_d_ready, tl_d_error;
  logic [2:0]  tl_d_opcode;
  logic [7:0]  tl_d_source;
  logic [31:0] tl_d_data;

  sram2tlul_ost #(
    .SramAw(12), .Outstanding(4), .TlBaseAddr(32'h1000_0000)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_write(mem_write),
    .mem_addr(mem_addr), .mem_wmask(mem_wmask), .mem_wdata(mem_wdata),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_error(mem_error),
    .tl_a_valid(tl_a_valid), .tl_a_ready(tl_a_ready), .tl_a_opcode(tl_a_opcode),
    .tl_a_address(tl_a_address), .tl_a_source(tl_a_source), .tl_a_mask(tl_a_mask),
    .tl_a_data(tl_a_data), .tl_d_valid(tl_d_valid), .tl_d_ready(tl_d_ready),
    .tl_d_opcode(tl_d_opcode), .tl_d_source(tl_d_source), .tl_d_data(tl_d_data),
    .tl_d_error(tl_d_error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  src;
    bit          wr;
    bit          ret;
    logic [31:0] data;
    bit          err;
  } ent_t;

  ent_t        q[$];
  int          wsrc;
  bit          rdy;
  bit          exp_rv;
  logic [31:0] exp_rd;
  logic [1:0]  exp_err;
  int          checks;
  int          errors;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle with the currently driven inputs, checked against the model
  task automatic step();
    bit exp_av, exp_gnt, found, mis;
    #1;
    exp_av  = !rst && mem_req && (q.size() < 4);
    exp_gnt = exp_av && tl_a_ready;
    chk("a_valid", tl_a_valid, exp_av);
    chk("gnt", mem_gnt, exp_gnt);
    if (exp_gnt) begin
      chk("a_addr", tl_a_address, 32'h1000_0000 | (32'(mem_addr) * 4));
      chk("a_op", tl_a_opcode, !mem_write ? 3'd4 : (mem_wmask == 4'hF ? 3'd0 : 3'd1));
      chk("a_mask", tl_a_mask, mem_write ? mem_wmask : 4'hF);
      chk("a_src", tl_a_source, 8'(wsrc));
      chk("a_data", tl_a_data, mem_wdata);
    end
    exp_rv = 1'b0;
    if (rst) begin
      q.delete();
      wsrc    = 0;
      rdy     = 1'b0;
      exp_rd  = 32'h0;
      exp_err = 2'b00;
    end else begin
      found = 1'b0;
      if (tl_d_valid && rdy && tl_d_source[7:2] == 6'd0) begin
        for (int i = 0; i < q.size(); i++) begin
          if (!found && !q[i].ret && q[i].src == tl_d_source[1:0]) begin
            found = 1'b1;
            mis   = 1'b0;
`ifdef SRAM2TLUL_RSP_CHK_EN
            mis = q[i].wr ? (tl_d_opcode != 3'd0) : (tl_d_opcode != 3'd1);
`endif
            q[i].ret  = 1'b1;
            q[i].err  = tl_d_error || mis;
            q[i].data = (q[i].wr || mis) ? 32'h0 : tl_d_data;
          end
        end
      end
      if (q.size() > 0 && q[0].ret) begin
        exp_rv  = 1'b1;
        exp_rd  = q[0].data;
        exp_err = {2{q[0].err}};
        void'(q.pop_front());
      end
      if (exp_gnt) begin
        q.push_back('{src: 2'(wsrc), wr: mem_write, ret: 1'b0, data: 32'h0, err: 1'b0});
        wsrc = (wsrc + 1) % 4;
      end
      rdy = 1'b1;
    end
    @(posedge clk);
    #1;
    chk("d_ready", tl_d_ready, rdy);
    chk("rvalid", mem_rvalid, exp_rv);
    if (exp_rv || rst) begin
      chk("rdata", mem_rdata, exp_rd);
      chk("error", mem_error, exp_err);
    end
    @(negedge clk);
  endtask

  task automatic req(input logic w, input logic [11:0] a, input logic [3:0] m, input logic [31:0] d);
    mem_req = 1'b1; mem_write = w; mem_addr = a; mem_wmask = m; mem_wdata = d;
    tl_a_ready = 1'b1;
    step();
    mem_req = 1'b0;
  endtask

  task automatic beat(input logic [7:0] src, input logic [2:0] op, input logic [31:0] d, input logic e);
    tl_d_valid = 1'b1; tl_d_source = src; tl_d_opcode = op; tl_d_data = d; tl_d_error = e;
    step();
    tl_d_valid = 1'b0;
  endtask

  task automatic drain();
    for (int g = 0; g < 16 && q.size() > 0; g++) begin
      if (!q[0].ret) beat({6'd0, q[0].src}, q[0].wr ? 3'd0 : 3'd1, $urandom, 1'b0);
      else step();
    end
  endtask

  initial begin
    int gnts;
    logic [7:0] s0, s1, s2;
    checks = 0; errors = 0; wsrc = 0; rdy = 1'b0;
    mem_req = 1'b0; mem_write = 1'b0; mem_addr = '0; mem_wmask = '0; mem_wdata = '0;
    tl_a_ready = 1'b1; tl_d_valid = 1'b0; tl_d_opcode = '0; tl_d_source = '0;
    tl_d_data = '0; tl_d_error = 1'b0;

    // Reset with a pending request: A channel must stay quiet
    rst = 1'b1; mem_req = 1'b1;
    step(); step();
    rst = 1'b0; mem_req = 1'b0;
    step();

    // Single read with base address
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 12'h010;
    #1;
    chk("r39_addr", tl_a_address, 32'h1000_0040);
    chk("r39_op", tl_a_opcode, 3'd4);
    chk("r39_mask", tl_a_mask, 4'hF);
    chk("r39_src", tl_a_source, 8'd0);
    step();
    mem_req = 1'b0;
    beat(8'd0, 3'd1, 32'hCAFE_F00D, 1'b0);
    chk("r39_rdata", mem_rdata, 32'hCAFE_F00D);

    // Partial and full writes
    mem_req = 1'b1; mem_write = 1'b1; mem_wmask = 4'b0011; mem_wdata = 32'h1234_5678;
    #1;
    chk("r40_op", tl_a_opcode, 3'd1);
    chk("r40_mask", tl_a_mask, 4'h3);
    step();
    mem_req = 1'b0;
    beat(8'd1, 3'd0, 32'hFFFF_FFFF, 1'b0);
    chk("r40_rdata", mem_rdata, 32'h0);
    chk("r40_err", mem_error, 2'b00);
    req(1'b1, 12'h3FF, 4'hF, 32'hA5A5_5A5A);
    drain();

    // Slot budget: six back-to-back reads, no responses
    gnts = 0;
    mem_req = 1'b1; mem_write = 1'b0;
    for (int i = 0; i < 6; i++) begin
      mem_addr = 12'(i);
      #1;
      if (mem_gnt) gnts++;
      step();
    end
    chk("r41_gnts", gnts, 4);
    tl_d_valid = 1'b1; tl_d_source = {6'd0, q[0].src}; tl_d_opcode = 3'd1;
    tl_d_data = 32'h0BAD_0001; tl_d_error = 1'b0;
    #1;
    chk("r41_blk", mem_gnt, 1'b0);
    step();
    tl_d_valid = 1'b0;
    #1;
    chk("r41_free", mem_gnt, 1'b1);
    step();
    mem_req = 1'b0;
    drain();

    // Out-of-order responses, in-order release
    s0 = 8'(wsrc); req(1'b0, 12'h100, 4'h0, 32'h0);
    s1 = 8'(wsrc); req(1'b0, 12'h101, 4'h0, 32'h0);
    s2 = 8'(wsrc); req(1'b0, 12'h102, 4'h0, 32'h0);
    beat(s2, 3'd1, 32'h2222_2222, 1'b0);
    chk("r42_hold", mem_rvalid, 1'b0);
    beat(s0, 3'd1, 32'h0000_0000, 1'b0);
    chk("r42_d0", mem_rdata, 32'h0000_0000);
    beat(s1, 3'd1, 32'h1111_1111, 1'b0);
    chk("r42_d1", mem_rdata, 32'h1111_1111);
    step();
    chk("r42_d2", mem_rdata, 32'h2222_2222);

    // Error propagation and opcode checking
    s0 = 8'(wsrc); req(1'b0, 12'h200, 4'h0, 32'h0);
    beat(s0, 3'd1, 32'h7777_7777, 1'b1);
    chk("r43_err", mem_error, 2'b11);
    s0 = 8'(wsrc); req(1'b0, 12'h201, 4'h0, 32'h0);
    beat(s0, 3'd0, 32'hDEAD_BEEF, 1'b0);
`ifdef SRAM2TLUL_RSP_CHK_EN
    chk("r43_chk_err", mem_error, 2'b11);
    chk("r43_chk_data", mem_rdata, 32'h0);
`else
    chk("r43_nochk_err", mem_error, 2'b00);
    chk("r43_nochk_data", mem_rdata, 32'hDEAD_BEEF);
`endif

    // Discards: unknown source, upper source bits, duplicate beat
    beat(8'd2, 3'd1, 32'h5555_5555, 1'b0);
    s0 = 8'(wsrc); req(1'b0, 12'h300, 4'h0, 32'h0);
    s1 = 8'(wsrc); req(1'b0, 12'h301, 4'h0, 32'h0);
    beat(s0 | 8'h04, 3'd1, 32'h6666_6666, 1'b0);
    beat(s1, 3'd1, 32'h8888_8888, 1'b0);
    beat(s1, 3'd1, 32'h9999_9999, 1'b1);
    beat(s0, 3'd1, 32'hAAAA_AAAA, 1'b0);
    chk("dup_d0", mem_rdata, 32'hAAAA_AAAA);
    step();
    chk("dup_d1", mem_rdata, 32'h8888_8888);
    chk("dup_err", mem_error, 2'b00);

    // Reset with three in flight, then stale responses
    s0 = 8'(wsrc); req(1'b0, 12'h400, 4'h0, 32'h0);
    s1 = 8'(wsrc); req(1'b0, 12'h401, 4'h0, 32'h0);
    s2 = 8'(wsrc); req(1'b1, 12'h402, 4'h5, 32'h0);
    rst = 1'b1; step();
    rst = 1'b0; step();
    beat(s0, 3'd1, 32'h1, 1'b0);
    beat(s1, 3'd1, 32'h2, 1'b0);
    beat(s2, 3'd0, 32'h3, 1'b0);
    chk("r44_quiet", mem_rvalid, 1'b0);
    mem_req = 1'b1; mem_write = 1'b0; mem_addr = 12'h055;
    #1;
    chk("r44_src0", tl_a_source, 8'd0);
    step();
    mem_req = 1'b0;
    drain();

    // Random traffic with out-of-order responses
    for (int c = 0; c < 400; c++) begin
      int cand[$];
      int pick;
      cand.delete();
      mem_req    = ($urandom_range(0, 3) != 0);
      mem_write  = $urandom_range(0, 1) == 1;
      mem_addr   = 12'($urandom);
      mem_wmask  = ($urandom_range(0, 3) == 0) ? 4'hF : 4'($urandom);
      mem_wdata  = $urandom;
      tl_a_ready = ($urandom_range(0, 3) != 0);
      for (int i = 0; i < q.size(); i++) if (!q[i].ret) cand.push_back(i);
      tl_d_valid = 1'b0;
      if (cand.size() > 0 && $urandom_range(0, 2) != 0) begin
        pick        = cand[$urandom_range(0, cand.size() - 1)];
        tl_d_valid  = 1'b1;
        tl_d_source = {6'd0, q[pick].src};
        tl_d_opcode = q[pick].wr ? 3'd0 : 3'd1;
        if ($urandom_range(0, 9) == 0) tl_d_opcode = ~tl_d_opcode & 3'd1;
        tl_d_error  = ($urandom_range(0, 7) == 0);
        tl_d_data   = $urandom;
      end else if ($urandom_range(0, 9) == 0) begin
        tl_d_valid  = 1'b1;
        tl_d_source = 8'($urandom);
        tl_d_opcode = 3'($urandom_range(0, 1));
        tl_d_error  = 1'b0;
        tl_d_data   = $urandom;
      end
      step();
    end
    mem_req = 1'b0; tl_d_valid = 1'b0; tl_a_ready = 1'b1;
    drain();
    step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
